// File: rtl/gamma_lut_rt.sv
// gamma_lut_rt: runtime-reloadable per-channel gamma LUT on an AXI4-Stream
// video path, double-buffered with bank swap aligned to start-of-frame.
module gamma_lut_rt #(
    parameter int PX_WIDTH = 10,
    parameter int CHANNELS = 3,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int DW = CHANNELS * PX_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                video_i_tvalid,
    output logic                video_i_tready,
    input  logic [DW-1:0]       video_i_tdata,
    input  logic                video_i_tuser,
    input  logic                video_i_tlast,
    output logic                video_o_tvalid,
    input  logic                video_o_tready,
    output logic [DW-1:0]       video_o_tdata,
    output logic                video_o_tuser,
    output logic                video_o_tlast,
    input  logic                bypass_i,
    input  logic                lut_wr_en_i,
    input  logic [CW-1:0]       lut_wr_chan_i,
    input  logic [PX_WIDTH-1:0] lut_wr_addr_i,
    input  logic [PX_WIDTH-1:0] lut_wr_data_i,
    input  logic                lut_swap_req_i,
    output logic                lut_swap_pending_o,
    output logic                active_bank_o
);

    localparam int DEPTH = 1 << PX_WIDTH;

    logic          en;
    logic          acc;
    logic          swap_now;
    logic          bank_q;
    logic          bank_d;
    logic          pend_q;
    logic          pend_d;

    logic          s1_valid_q;
    logic          s1_user_q;
    logic          s1_last_q;
    logic          s1_byp_q;
    logic [DW-1:0] s1_pix_q;
    logic [DW-1:0] rd_all;

    logic          vo_valid_q;
    logic          vo_user_q;
    logic          vo_last_q;
    logic [DW-1:0] vo_data_q;
    logic [DW-1:0] vo_data_d;

    assign en             = !vo_valid_q || video_o_tready;
    assign video_i_tready = en;
    assign acc            = video_i_tvalid && en;
    assign swap_now       = acc && video_i_tuser && (pend_q || lut_swap_req_i);

    // Next bank/pending state; bank_d also selects the bank for this beat
    always_comb begin
        bank_d = bank_q;
        pend_d = pend_q | lut_swap_req_i;
        if (swap_now) begin
            bank_d = ~bank_q;
            pend_d = 1'b0;
        end
    end

    // Bank select and swap-pending registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bank_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            bank_q <= bank_d;
            pend_q <= pend_d;
        end
    end

    assign active_bank_o      = bank_q;
    assign lut_swap_pending_o = pend_q;

    // Entries are stored XORed with their address, so the all-zero
    // power-up contents of the RAM read back as the identity curve.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [PX_WIDTH-1:0] mem_q [2][DEPTH];
        logic [PX_WIDTH-1:0] rd_q;
        logic [PX_WIDTH-1:0] pix;
        logic                wr_hit;

        assign pix    = video_i_tdata[c*PX_WIDTH +: PX_WIDTH];
        assign wr_hit = lut_wr_en_i && (lut_wr_chan_i == CW'(c));

        // Write port: always into the bank not currently active
        always_ff @(posedge clk_i) begin
            if (wr_hit) begin
                mem_q[~bank_q][lut_wr_addr_i] <= lut_wr_data_i ^ lut_wr_addr_i;
            end
        end

        // Registered read port, advancing with the pipeline
        always_ff @(posedge clk_i) begin
            if (en) begin
                rd_q <= mem_q[bank_d][pix];
            end
        end

        assign rd_all[c*PX_WIDTH +: PX_WIDTH] = rd_q;
    end

    // Stage 1: valid, sideband, bypass flag and raw pixel
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_user_q  <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_byp_q   <= 1'b0;
            s1_pix_q   <= '0;
        end else if (en) begin
            s1_valid_q <= video_i_tvalid;
            s1_user_q  <= video_i_tuser;
            s1_last_q  <= video_i_tlast;
            s1_byp_q   <= bypass_i;
            s1_pix_q   <= video_i_tdata;
        end
    end

    // Decode the looked-up value or pass the raw pixel through
    always_comb begin
        vo_data_d = rd_all ^ s1_pix_q;
        if (s1_byp_q) begin
            vo_data_d = s1_pix_q;
        end
    end

    // Stage 2: output register, held while downstream stalls
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vo_valid_q <= 1'b0;
            vo_user_q  <= 1'b0;
            vo_last_q  <= 1'b0;
            vo_data_q  <= '0;
        end else if (en) begin
            vo_valid_q <= s1_valid_q;
            vo_user_q  <= s1_user_q;
            vo_last_q  <= s1_last_q;
            vo_data_q  <= vo_data_d;
        end
    end

    assign video_o_tvalid = vo_valid_q;
    assign video_o_tuser  = vo_user_q;
    assign video_o_tlast  = vo_last_q;
    assign video_o_tdata  = vo_data_q;

endmodule

// File: tb/tb_gamma_lut_rt.sv
// tb_gamma_lut_rt: scoreboard bench for gamma_lut_rt with a LUT/bank model,
// backpressure, bypass, same-cycle swap/write and mid-frame reset.
`timescale 1ns/1ps
module tb_gamma_lut_rt;

    localparam int PW = 10;
    localparam int CH = 3;
    localparam int DW = PW * CH;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          video_i_tvalid = 1'b0;
    logic          video_i_tready;
    logic [DW-1:0] video_i_tdata = '0;
    logic          video_i_tuser = 1'b0;
    logic          video_i_tlast = 1'b0;
    logic          video_o_tvalid;
    logic          video_o_tready = 1'b1;
    logic [DW-1:0] video_o_tdata;
    logic          video_o_tuser;
    logic          video_o_tlast;
    logic          bypass_i = 1'b0;
    logic          lut_wr_en_i = 1'b0;
    logic [1:0]    lut_wr_chan_i = '0;
    logic [PW-1:0] lut_wr_addr_i = '0;
    logic [PW-1:0] lut_wr_data_i = '0;
    logic          lut_swap_req_i = 1'b0;
    logic          lut_swap_pending_o;
    logic          active_bank_o;

    gamma_lut_rt dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .video_i_tvalid     (video_i_tvalid),
        .video_i_tready     (video_i_tready),
        .video_i_tdata      (video_i_tdata),
        .video_i_tuser      (video_i_tuser),
        .video_i_tlast      (video_i_tlast),
        .video_o_tvalid     (video_o_tvalid),
        .video_o_tready     (video_o_tready),
        .video_o_tdata      (video_o_tdata),
        .video_o_tuser      (video_o_tuser),
        .video_o_tlast      (video_o_tlast),
        .bypass_i           (bypass_i),
        .lut_wr_en_i        (lut_wr_en_i),
        .lut_wr_chan_i      (lut_wr_chan_i),
        .lut_wr_addr_i      (lut_wr_addr_i),
        .lut_wr_data_i      (lut_wr_data_i),
        .lut_swap_req_i     (lut_swap_req_i),
        .lut_swap_pending_o (lut_swap_pending_o),
        .active_bank_o      (active_bank_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          user;
        logic          last;
        logic [31:0]   cyc;
    } exp_t;

    exp_t          sb[$];
    logic [PW-1:0] m_lut [CH][2][1024];
    logic          m_bank = 1'b0;
    logic          m_pend = 1'b0;
    int            n_tests = 0;
    int            n_fail = 0;
    logic [31:0]   cyc = 0;
    bit            rnd_rdy = 1'b0;
    bit            lat_chk = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW+2:0] prev_out = '0;

    localparam logic [DW-1:0] PIX_A = {10'h3FF, 10'h200, 10'h001};

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Downstream ready: constant high or ~50% random
    always begin
        @(posedge clk_i);
        #1;
        video_o_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Reference model and scoreboard, sampled mid-cycle
    always @(negedge clk_i) begin
        exp_t          e;
        logic          sel;
        logic          sw;
        logic [DW-1:0] ex;
        logic [PW-1:0] pin;
        sw = 1'b0;
        if (rst_i) begin
            sb.delete();
            m_bank = 1'b0;
            m_pend = 1'b0;
            prev_stall = 1'b0;
            check("rst_ovalid", 64'(video_o_tvalid), 0);
            check("rst_tready", 64'(video_i_tready), 1);
        end else begin
            check("bank", 64'(active_bank_o), 64'(m_bank));
            check("pending", 64'(lut_swap_pending_o), 64'(m_pend));
            if (prev_stall) begin
                check("hold",
                      64'({video_o_tvalid, video_o_tuser,
                           video_o_tlast, video_o_tdata}),
                      64'(prev_out));
            end
            if (video_o_tvalid && video_o_tready) begin
                check("spurious_beat", 64'(sb.size() == 0), 0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("data", 64'(video_o_tdata), 64'(e.data));
                    check("tuser", 64'(video_o_tuser), 64'(e.user));
                    check("tlast", 64'(video_o_tlast), 64'(e.last));
                    if (lat_chk) check("latency", 64'(cyc - e.cyc), 2);
                end
            end
            prev_stall = video_o_tvalid && !video_o_tready;
            prev_out = {video_o_tvalid, video_o_tuser,
                        video_o_tlast, video_o_tdata};
            if (video_i_tvalid && video_i_tready) begin
                sw = video_i_tuser && (m_pend || lut_swap_req_i);
                sel = sw ? ~m_bank : m_bank;
                for (int c = 0; c < CH; c++) begin
                    pin = video_i_tdata[c*PW +: PW];
                    ex[c*PW +: PW] = bypass_i ? pin : m_lut[c][sel][pin];
                end
                e.data = ex;
                e.user = video_i_tuser;
                e.last = video_i_tlast;
                e.cyc = cyc;
                sb.push_back(e);
            end
            if (lut_wr_en_i && lut_wr_chan_i < 2'(CH)) begin
                m_lut[lut_wr_chan_i][~m_bank][lut_wr_addr_i] = lut_wr_data_i;
            end
            if (sw) begin
                m_bank = ~m_bank;
                m_pend = 1'b0;
            end else if (lut_swap_req_i) begin
                m_pend = 1'b1;
            end
        end
        cyc = cyc + 1;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic u,
                        input logic l, input logic b);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        video_i_tvalid = 1'b1;
        video_i_tdata = d;
        video_i_tuser = u;
        video_i_tlast = l;
        bypass_i = b;
        while (!acc && n < 200) begin
            @(negedge clk_i);
            acc = video_i_tready;
            if (!acc) begin
                n++;
                @(posedge clk_i);
                #1;
            end
        end
        if (!acc) check("accept_timeout", 64'(acc), 1);
        @(posedge clk_i);
        #1;
        video_i_tvalid = 1'b0;
        video_i_tuser = 1'b0;
        video_i_tlast = 1'b0;
        bypass_i = 1'b0;
    endtask

    task automatic lut_write(input logic [1:0] ch, input logic [PW-1:0] a,
                             input logic [PW-1:0] d);
        lut_wr_en_i = 1'b1;
        lut_wr_chan_i = ch;
        lut_wr_addr_i = a;
        lut_wr_data_i = d;
        idle(1);
        lut_wr_en_i = 1'b0;
    endtask

    task automatic swap_pulse();
        lut_swap_req_i = 1'b1;
        idle(1);
        lut_swap_req_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int c = 0; c < CH; c++)
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 1024; i++)
                    m_lut[c][b][i] = PW'(i);

        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle(2);
        check("reset_bank", 64'(active_bank_o), 0);
        check("reset_tready", 64'(video_i_tready), 1);

        // identity 4x2 frame
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++)
                send(PIX_A, y == 0 && x == 0, x == 3, 1'b0);
        idle(4);

        // inverted curve on channel 0 of the shadow bank
        for (int i = 0; i < 1024; i++)
            lut_write(2'd0, PW'(i), 10'h3FF - PW'(i));
        send(PIX_A, 1'b1, 1'b0, 1'b0);
        send(PIX_A, 1'b0, 1'b0, 1'b0);
        swap_pulse();
        check("pend_mid_frame", 64'(lut_swap_pending_o), 1);
        send(PIX_A, 1'b0, 1'b0, 1'b0);
        send(PIX_A, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("bank_before_sof", 64'(active_bank_o), 0);
        send(PIX_A, 1'b1, 1'b0, 1'b0);
        send(PIX_A, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("pend_after_sof", 64'(lut_swap_pending_o), 0);
        check("bank_after_sof", 64'(active_bank_o), 1);

        // backpressure with incrementing pattern
        rnd_rdy = 1'b1;
        for (int i = 0; i < 64; i++)
            send({PW'(i + 2), PW'(i + 1), PW'(i)}, i == 0, i % 8 == 7, 1'b0);
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            idle(1);
            n++;
        end
        rnd_rdy = 1'b0;
        idle(3);

        // bypass on alternate beats, latency checked
        lat_chk = 1'b1;
        for (int i = 0; i < 16; i++)
            send({PW'(3 * i), PW'(2 * i + 7), PW'(40 * i + 1)},
                 i == 0, i == 15, 1'(i % 2));
        idle(4);
        lat_chk = 1'b0;

        // swap request, write and SOF in one cycle
        lut_swap_req_i = 1'b1;
        lut_wr_en_i = 1'b1;
        lut_wr_chan_i = 2'd0;
        lut_wr_addr_i = 10'd5;
        lut_wr_data_i = 10'h123;
        send({10'd5, 10'd5, 10'd5}, 1'b1, 1'b0, 1'b0);
        lut_swap_req_i = 1'b0;
        lut_wr_en_i = 1'b0;
        send({10'd5, 10'd5, 10'd5}, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("bank_simul", 64'(active_bank_o), 0);

        // reset with two beats in flight and a swap pending
        swap_pulse();
        check("pend_before_rst", 64'(lut_swap_pending_o), 1);
        send({10'd7, 10'd7, 10'd7}, 1'b0, 1'b0, 1'b0);
        send({10'd8, 10'd8, 10'd8}, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b1;
        #1;
        check("rst_async_valid", 64'(video_o_tvalid), 0);
        idle(3);
        rst_i = 1'b0;
        idle(10);
        check("rst_bank", 64'(active_bank_o), 0);
        check("rst_pend", 64'(lut_swap_pending_o), 0);
        send({10'd5, 10'd5, 10'd5}, 1'b1, 1'b1, 1'b0);
        swap_pulse();
        send(PIX_A, 1'b1, 1'b1, 1'b0);
        idle(4);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        check("drain", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
